// File: rtl/bsg_fifo_banked_scheduler.sv
// Round-robin enqueue/dequeue sequencer for a FIFO striped across N 1r1w banks.
// Keeps global occupancy and a sticky protocol-violation flag.
module bsg_fifo_banked_scheduler #(
    parameter int num_banks_p = 2,
    parameter int bank_els_p = 128,
    localparam int lg_banks_lp = $clog2(num_banks_p),
    localparam int count_width_lp = $clog2(num_banks_p*bank_els_p+1)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    output logic                      ready_o,
    output logic [num_banks_p-1:0]    bank_v_o,
    input  logic [num_banks_p-1:0]    bank_ready_i,
    output logic [lg_banks_lp-1:0]    wr_bank_o,
    input  logic [num_banks_p-1:0]    bank_v_i,
    output logic [num_banks_p-1:0]    bank_yumi_o,
    output logic [lg_banks_lp-1:0]    rd_bank_o,
    output logic                      v_o,
    input  logic                      yumi_i,
    output logic [count_width_lp-1:0] count_o,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      error_o
);

    localparam logic [lg_banks_lp-1:0] last_ptr_lp =
        lg_banks_lp'(num_banks_p-1);
    localparam logic [count_width_lp-1:0] max_count_lp =
        count_width_lp'(num_banks_p*bank_els_p);

    logic [lg_banks_lp-1:0]    wr_ptr_r;
    logic [lg_banks_lp-1:0]    rd_ptr_r;
    logic [count_width_lp-1:0] count_r;
    logic                      error_r;

    logic enq;
    logic deq;
    logic bad_yumi;
    logic err_event;

    assign count_o = count_r;
    assign empty_o = (count_r == '0);
    assign full_o  = (count_r == max_count_lp);
    assign error_o = error_r;

    assign wr_bank_o = wr_ptr_r;
    assign ready_o   = bank_ready_i[wr_ptr_r] & ~full_o;
    assign enq       = v_i & ready_o;
    assign bank_v_o  = num_banks_p'(enq) << wr_ptr_r;

    // Only the head bank's valid matters; others are ignored to keep order.
    assign rd_bank_o   = rd_ptr_r;
    assign v_o         = bank_v_i[rd_ptr_r];
    assign deq         = yumi_i & v_o;
    assign bank_yumi_o = num_banks_p'(deq) << rd_ptr_r;

    assign bad_yumi  = yumi_i & ~v_o;
    assign err_event = bad_yumi | (v_o & empty_o);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            error_r  <= 1'b0;
        end else begin
            if (enq)
                wr_ptr_r <= (wr_ptr_r == last_ptr_lp) ? '0 : wr_ptr_r + 1'b1;
            if (deq)
                rd_ptr_r <= (rd_ptr_r == last_ptr_lp) ? '0 : rd_ptr_r + 1'b1;
            if (enq & ~deq)
                count_r <= count_r + 1'b1;
            else if (deq & ~enq & ~empty_o)
                count_r <= count_r - 1'b1;
            if (err_event)
                error_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bsg_fifo_banked_scheduler.sv
// Bench for bsg_fifo_banked_scheduler: directed vector table, wrap checks
// on a 3-bank instance, and a randomized run against bank models.
module tb_bsg_fifo_banked_scheduler;

    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       v_i = 1'b0, yumi_i = 1'b0;
    logic [1:0] bank_ready_i = 2'b11, bank_v_i = 2'b00;
    logic       ready_o, v_o, empty_o, full_o, error_o;
    logic [1:0] bank_v_o, bank_yumi_o;
    logic       wr_bank_o, rd_bank_o;
    logic [3:0] count_o;

    logic       v3 = 1'b0, y3 = 1'b0;
    logic [2:0] br3 = 3'b111, bv3 = 3'b000;
    logic       rdy3, vo3, empty3, full3, err3;
    logic [2:0] bvo3, byo3;
    logic [1:0] wb3, rb3;
    logic [3:0] cnt3;

    always #5 clk_i = ~clk_i;

    bsg_fifo_banked_scheduler #(.num_banks_p(2), .bank_els_p(4)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .v_i(v_i), .ready_o(ready_o),
        .bank_v_o(bank_v_o), .bank_ready_i(bank_ready_i),
        .wr_bank_o(wr_bank_o), .bank_v_i(bank_v_i),
        .bank_yumi_o(bank_yumi_o), .rd_bank_o(rd_bank_o),
        .v_o(v_o), .yumi_i(yumi_i), .count_o(count_o),
        .empty_o(empty_o), .full_o(full_o), .error_o(error_o)
    );

    bsg_fifo_banked_scheduler #(.num_banks_p(3), .bank_els_p(4)) dut3 (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .v_i(v3), .ready_o(rdy3),
        .bank_v_o(bvo3), .bank_ready_i(br3),
        .wr_bank_o(wb3), .bank_v_i(bv3),
        .bank_yumi_o(byo3), .rd_bank_o(rb3),
        .v_o(vo3), .yumi_i(y3), .count_o(cnt3),
        .empty_o(empty3), .full_o(full3), .error_o(err3)
    );

    typedef struct {
        logic       v, y;
        logic [1:0] br, bv;
        logic       rdy;
        logic [1:0] bvo, byo;
        logic       wb, rb, vo;
        logic [3:0] cnt;
        logic       fl, em, er;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_fail = 0;

    function automatic vec_t mk(int v, int y, int br, int bv, int rdy,
                                int bvo, int byo, int wb, int rb, int vo,
                                int cnt, int fl, int em, int er);
        vec_t r;
        r.v = 1'(v);     r.y = 1'(y);
        r.br = 2'(br);   r.bv = 2'(bv);
        r.rdy = 1'(rdy); r.bvo = 2'(bvo); r.byo = 2'(byo);
        r.wb = 1'(wb);   r.rb = 1'(rb);   r.vo = 1'(vo);
        r.cnt = 4'(cnt); r.fl = 1'(fl);   r.em = 1'(em); r.er = 1'(er);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [14:0] dut_pack();
        return {ready_o, bank_v_o, bank_yumi_o, wr_bank_o, rd_bank_o,
                v_o, count_o, full_o, empty_o, error_o};
    endfunction

    int bq[2][$];
    int sb[$];

    initial begin
        vec_t r;
        int   exp_wp, exp_rp, tok, data;
        logic enq_s, deq_s, exp_rdy;

        //      v y br bv  rdy bvo byo wb rb vo cnt fl em er
        tbl.push_back(mk(0,0,3,0, 1,0,0, 0,0,0, 0,0,1,0));
        tbl.push_back(mk(1,0,3,0, 1,1,0, 0,0,0, 0,0,1,0));
        tbl.push_back(mk(1,0,3,0, 1,2,0, 1,0,0, 1,0,0,0));
        tbl.push_back(mk(1,0,3,0, 1,1,0, 0,0,0, 2,0,0,0));
        tbl.push_back(mk(1,0,3,0, 1,2,0, 1,0,0, 3,0,0,0));
        tbl.push_back(mk(1,0,3,0, 1,1,0, 0,0,0, 4,0,0,0));
        tbl.push_back(mk(0,0,3,0, 1,0,0, 1,0,0, 5,0,0,0));
        tbl.push_back(mk(1,0,3,0, 1,2,0, 1,0,0, 5,0,0,0));
        tbl.push_back(mk(1,0,3,0, 1,1,0, 0,0,0, 6,0,0,0));
        tbl.push_back(mk(1,0,3,0, 1,2,0, 1,0,0, 7,0,0,0));
        tbl.push_back(mk(1,0,3,0, 0,0,0, 0,0,0, 8,1,0,0));
        tbl.push_back(mk(1,0,3,0, 0,0,0, 0,0,0, 8,1,0,0));
        tbl.push_back(mk(0,1,3,1, 0,0,1, 0,0,1, 8,1,0,0));
        tbl.push_back(mk(0,0,3,0, 1,0,0, 0,1,0, 7,0,0,0));
        tbl.push_back(mk(0,1,3,2, 1,0,2, 0,1,1, 7,0,0,0));
        tbl.push_back(mk(0,1,3,1, 1,0,1, 0,0,1, 6,0,0,0));
        tbl.push_back(mk(0,1,3,2, 1,0,2, 0,1,1, 5,0,0,0));
        tbl.push_back(mk(0,1,3,1, 1,0,1, 0,0,1, 4,0,0,0));
        tbl.push_back(mk(1,1,3,2, 1,1,2, 0,1,1, 3,0,0,0));
        tbl.push_back(mk(0,0,3,0, 1,0,0, 1,0,0, 3,0,0,0));
        tbl.push_back(mk(1,0,3,0, 1,2,0, 1,0,0, 3,0,0,0));
        tbl.push_back(mk(1,0,2,0, 0,0,0, 0,0,0, 4,0,0,0));
        tbl.push_back(mk(1,0,2,0, 0,0,0, 0,0,0, 4,0,0,0));
        tbl.push_back(mk(1,0,3,0, 1,1,0, 0,0,0, 4,0,0,0));
        tbl.push_back(mk(0,0,3,0, 1,0,0, 1,0,0, 5,0,0,0));
        tbl.push_back(mk(0,1,3,2, 1,0,0, 1,0,0, 5,0,0,0));
        tbl.push_back(mk(0,0,3,0, 1,0,0, 1,0,0, 5,0,0,1));
        tbl.push_back(mk(0,1,3,1, 1,0,1, 1,0,1, 5,0,0,1));
        tbl.push_back(mk(0,0,3,0, 1,0,0, 1,1,0, 4,0,0,1));

        repeat (3) @(negedge clk_i);
        reset_n_i = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            r = tbl[i];
            @(negedge clk_i);
            v_i = r.v; yumi_i = r.y;
            bank_ready_i = r.br; bank_v_i = r.bv;
            #1;
            chk($sformatf("vec%0d", i), 32'(dut_pack()),
                32'({r.rdy, r.bvo, r.byo, r.wb, r.rb, r.vo,
                     r.cnt, r.fl, r.em, r.er}));
        end

        // Asynchronous reset between edges clears sticky error and count.
        @(negedge clk_i);
        v_i = 1'b1; yumi_i = 1'b0;
        bank_ready_i = 2'b11; bank_v_i = 2'b00;
        #2 reset_n_i = 1'b0;
        #1;
        chk("async_reset", 32'(dut_pack()),
            32'({1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0,
                 4'd0, 1'b0, 1'b1, 1'b0}));
        @(negedge clk_i);
        v_i = 1'b0;
        reset_n_i = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            v3 = 1'b1;
            #1;
            chk($sformatf("wrap_wr%0d", i), 32'({bvo3, wb3}),
                32'({3'(1 << (i % 3)), 2'(i % 3)}));
        end
        @(negedge clk_i);
        v3 = 1'b0;
        #1;
        chk("wrap_cnt", 32'({cnt3, wb3}), 32'({4'd4, 2'd1}));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            bv3 = 3'(1 << (i % 3)); y3 = 1'b1;
            #1;
            chk($sformatf("wrap_rd%0d", i), 32'({byo3, rb3, vo3}),
                32'({3'(1 << (i % 3)), 2'(i % 3), 1'b1}));
        end
        @(negedge clk_i);
        bv3 = 3'b000; y3 = 1'b0;
        #1;
        chk("wrap_end", 32'({cnt3, rb3, empty3, err3}),
            32'({4'd0, 2'd1, 1'b1, 1'b0}));

        exp_wp = 0; exp_rp = 0; tok = 100;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_i);
            v_i = ($urandom_range(0, 3) != 0);
            for (int b = 0; b < 2; b++) begin
                bank_ready_i[b] = (bq[b].size() < 4);
                bank_v_i[b] = (bq[b].size() != 0);
            end
            #1;
            yumi_i = v_o && ($urandom_range(0, 2) != 0);
            #1;
            exp_rdy = (bq[exp_wp].size() < 4) && (sb.size() < 8);
            enq_s = v_i & exp_rdy;
            deq_s = yumi_i & v_o;
            chk($sformatf("rand_state%0d", c),
                32'({ready_o, wr_bank_o, rd_bank_o, count_o, error_o}),
                32'({exp_rdy, 1'(exp_wp), 1'(exp_rp), 4'(sb.size()),
                     1'b0}));
            chk($sformatf("rand_strobe%0d", c),
                32'({bank_v_o, bank_yumi_o}),
                32'({2'(enq_s) << exp_wp, 2'(deq_s) << exp_rp}));
            @(posedge clk_i);
            if (deq_s) begin
                data = bq[exp_rp].pop_front();
                if (sb.size() == 0) begin
                    chk($sformatf("rand_order%0d", c), 32'(data), 32'hffff);
                end else begin
                    chk($sformatf("rand_order%0d", c),
                        32'(data), 32'(sb.pop_front()));
                end
                exp_rp = 1 - exp_rp;
            end
            if (enq_s) begin
                bq[exp_wp].push_back(tok);
                sb.push_back(tok);
                tok++;
                exp_wp = 1 - exp_wp;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
